// File: rtl/console_samp.sv
// Per-tick acquisition sequencer: one ADC conversion per channel per fs rise,
// samples streamed out on valid/ready, fd pulsed once the last beat is accepted.
module console_samp #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADC_TO = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              work,
  input  logic              fs,
  output logic              fd,
  output logic              adc_start,
  output logic [3:0]        adc_ch,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] adc_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_ch,
  output logic              out_last,
  output logic [15:0]       frame_cnt,
  output logic              overrun,
  output logic              adc_err
);

  localparam int unsigned     TO_W    = (ADC_TO < 1) ? 1 : $clog2(ADC_TO + 1);
  localparam logic [TO_W-1:0] TO_LIM  = TO_W'(ADC_TO);
  localparam logic [3:0]      LAST_CH = 4'(NUM_CH - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    PUSH = 3'd3,
    DONE = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic                fs_d_q, fs_d_d;
  logic [3:0]          ch_q, ch_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [3:0]          out_ch_q, out_ch_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic                overrun_q, overrun_d;
  logic                adc_err_q, adc_err_d;
  logic                start;

  assign start = fs & ~fs_d_q;

  always_comb begin
    state_d     = state_q;
    fs_d_d      = fs;
    ch_d        = ch_q;
    to_cnt_d    = to_cnt_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    frame_cnt_d = frame_cnt_q;
    overrun_d   = overrun_q;
    adc_err_d   = adc_err_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          ch_d    = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        to_cnt_d = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        if (adc_done) begin
          out_data_d = adc_data;
          out_ch_d   = ch_q;
          state_d    = PUSH;
        end else if (to_cnt_q == TO_LIM) begin
          out_data_d = '1;
          out_ch_d   = ch_q;
          adc_err_d  = 1'b1;
          state_d    = PUSH;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      PUSH: begin
        if (out_ready) begin
          if (ch_q == LAST_CH) begin
            state_d = DONE;
          end else begin
            ch_d    = ch_q + 4'd1;
            state_d = REQ;
          end
        end
      end
      DONE: begin
        frame_cnt_d = frame_cnt_q + 16'd1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A tick while busy is dropped, only flagged.
    if (start && state_q != IDLE) overrun_d = 1'b1;

    // Abort wins over everything in flight; status counters freeze.
    if (!work) begin
      state_d     = IDLE;
      fs_d_d      = 1'b0;
      frame_cnt_d = frame_cnt_q;
      overrun_d   = overrun_q;
      adc_err_d   = adc_err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fs_d_q      <= 1'b0;
      ch_q        <= '0;
      to_cnt_q    <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
      adc_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fs_d_q      <= fs_d_d;
      ch_q        <= ch_d;
      to_cnt_q    <= to_cnt_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
      adc_err_q   <= adc_err_d;
    end
  end

  assign adc_start = (state_q == REQ);
  assign adc_ch    = ch_q;
  assign out_valid = (state_q == PUSH);
  assign out_last  = (state_q == PUSH) && (ch_q == LAST_CH);
  assign fd        = (state_q == DONE);
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign frame_cnt = frame_cnt_q;
  assign overrun   = overrun_q;
  assign adc_err   = adc_err_q;

endmodule
